// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, field extraction and
// destination-register decode. Used by the decode, ALU and writeback stages.
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_CNT = 32;
    localparam int REG_AW  = 5;
    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;

    typedef struct packed {
        logic              has_dest;
        logic [REG_AW-1:0] addr;
    } dest_t;

    function automatic logic [5:0] f_opcode(input logic [INSTR_W-1:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [REG_AW-1:0] f_rs(input logic [INSTR_W-1:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [REG_AW-1:0] f_rt(input logic [INSTR_W-1:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [REG_AW-1:0] f_rd(input logic [INSTR_W-1:0] instr);
        return instr[15:11];
    endfunction

    function automatic logic [5:0] f_funct(input logic [INSTR_W-1:0] instr);
        return instr[5:0];
    endfunction

    // R-type writes rd, ALU-immediate and lw write rt; a target of r0 is
    // treated as "no destination" since r0 can never be pending.
    function automatic dest_t dest_reg(input logic [INSTR_W-1:0] instr);
        dest_t d;
        d.has_dest = 1'b0;
        d.addr     = 5'd0;
        case (f_opcode(instr))
            OP_RTYPE: begin
                d.has_dest = 1'b1;
                d.addr     = f_rd(instr);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
                d.has_dest = 1'b1;
                d.addr     = f_rt(instr);
            end
            default: begin
                d.has_dest = 1'b0;
                d.addr     = 5'd0;
            end
        endcase
        if (d.addr == 5'd0) begin
            d.has_dest = 1'b0;
        end else begin
            d.has_dest = d.has_dest;
        end
        return d;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: instruction input handshake, ALU operand output
// handshake and the writeback port from the memory/writeback stage.
interface id_stage_if;
    import mips_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [DATA_W-1:0]  out_reg_a;
    logic [DATA_W-1:0]  out_reg_b;
    logic               wb_en;
    logic [REG_AW-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;

    // Driver side: fetch, ALU consumer and writeback stage.
    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, out_instr, out_reg_a, out_reg_b
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, out_instr, out_reg_a, out_reg_b
    );
endinterface

// File: rtl/id_stage_gpr_file.sv
// 32x32 general-purpose register file: two asynchronous read ports, one
// synchronous write port, write-through bypass, r0 hardwired to zero.
module gpr_file
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem_r [REG_CNT];

    // Storage: cleared on reset, r0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port A with same-cycle write bypass.
    always_comb begin
        if (raddr_a == 5'd0) begin
            rdata_a = 32'd0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = mem_r[raddr_a];
        end
    end

    // Read port B with same-cycle write bypass.
    always_comb begin
        if (raddr_b == 5'd0) begin
            rdata_b = 32'd0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = mem_r[raddr_b];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: reads rs/rt operands, interlocks RAW/WAW hazards
// with a per-register pending scoreboard and holds a one-entry output slot
// feeding the ALU.
module id_stage
    import mips_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    id_stage_if.slave bus
);

    logic [REG_AW-1:0]  rs_s;
    logic [REG_AW-1:0]  rt_s;
    logic [REG_AW-1:0]  hold_rs_s;
    logic [REG_AW-1:0]  hold_rt_s;
    dest_t              dest_s;
    logic [DATA_W-1:0]  rd_a_s;
    logic [DATA_W-1:0]  rd_b_s;
    logic [REG_CNT-1:0] pending_r;
    logic [REG_CNT-1:0] pending_nxt_s;
    logic [REG_CNT-1:0] pend_eff_s;
    logic               wb_live_s;
    logic               slot_free_s;
    logic               hazard_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               out_valid_r;
    logic [INSTR_W-1:0] out_instr_r;
    logic [DATA_W-1:0]  out_reg_a_r;
    logic [DATA_W-1:0]  out_reg_b_r;

    // Field decode of the incoming and the held instruction.
    always_comb begin
        rs_s      = f_rs(bus.in_instr);
        rt_s      = f_rt(bus.in_instr);
        dest_s    = dest_reg(bus.in_instr);
        hold_rs_s = f_rs(out_instr_r);
        hold_rt_s = f_rt(out_instr_r);
        wb_live_s = bus.wb_en && (bus.wb_addr != 5'd0);
    end

    gpr_file u_gpr_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (rs_s),
        .rdata_a (rd_a_s),
        .raddr_b (rt_s),
        .rdata_b (rd_b_s),
        .we      (bus.wb_en),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data)
    );

    // Pending bits as seen this cycle: a same-cycle writeback already retires them.
    always_comb begin
        pend_eff_s = {REG_CNT{1'b0}};
        for (int i = 1; i < REG_CNT; i++) begin
            pend_eff_s[i] = pending_r[i] && !(bus.wb_en && (bus.wb_addr == REG_AW'(i)));
        end
    end

    // Hazard and handshake: r0 is never pending, so rs/rt = 0 never stall.
    always_comb begin
        slot_free_s = !out_valid_r || bus.out_ready;
        hazard_s    = pend_eff_s[rs_s] || pend_eff_s[rt_s] ||
                      (dest_s.has_dest && pend_eff_s[dest_s.addr]);
        in_ready_s  = slot_free_s && !hazard_s;
        accept_s    = bus.in_valid && in_ready_s;
    end

    // Scoreboard next state: writeback clears, accept with a destination sets (set wins).
    always_comb begin
        pending_nxt_s = pending_r;
        for (int i = 1; i < REG_CNT; i++) begin
            if (accept_s && dest_s.has_dest && (dest_s.addr == REG_AW'(i))) begin
                pending_nxt_s[i] = 1'b1;
            end else if (bus.wb_en && (bus.wb_addr == REG_AW'(i))) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {REG_CNT{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Output slot: load on accept, drain when free, refresh held operands on writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'd0;
            out_reg_a_r <= 32'd0;
            out_reg_b_r <= 32'd0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_instr_r <= bus.in_instr;
            out_reg_a_r <= rd_a_s;
            out_reg_b_r <= rd_b_s;
        end else if (slot_free_s) begin
            out_valid_r <= 1'b0;
        end else begin
            if (wb_live_s && (bus.wb_addr == hold_rs_s)) begin
                out_reg_a_r <= bus.wb_data;
            end
            if (wb_live_s && (bus.wb_addr == hold_rt_s)) begin
                out_reg_b_r <= bus.wb_data;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_instr = out_instr_r;
    assign bus.out_reg_a = out_reg_a_r;
    assign bus.out_reg_b = out_reg_b_r;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: expected ALU operand triples are queued
// on accept and compared when the stage presents them.
module tb_id_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t sb [$];
    logic [31:0] model_gpr [32];

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        tick();
        bus.wb_en = 1'b0;
        if (a != 5'd0) model_gpr[a] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 ||
            bus.out_reg_a !== 32'd0 || bus.out_reg_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: v=%b i=%h a=%h b=%h, want all 0",
                     bus.out_valid, bus.out_instr, bus.out_reg_a, bus.out_reg_b);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        exp_t e;
        logic [31:0] ins;
        do_wb(5'd1, 32'd6);
        do_wb(5'd2, 32'd9);
        ins = enc_r(5'd1, 5'd2, 5'd3, FN_ADDU);
        bus.in_instr = ins;
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b want 1", bus.in_ready);
        end
        sb.push_back({ins, model_gpr[1], model_gpr[2]});
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL basic_out: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_instr !== e.instr ||
                bus.out_reg_a !== e.a || bus.out_reg_b !== e.b) begin
                errors++;
                $display("FAIL basic_out: got v=%b i=%h a=%h b=%h want v=1 i=%h a=%h b=%h",
                         bus.out_valid, bus.out_instr, bus.out_reg_a, bus.out_reg_b, e.instr, e.a, e.b);
            end
        end
        bus.in_instr = enc_r(5'd3, 5'd0, 5'd8, FN_ADDU);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_r3_raw: in_ready got %b want 0", bus.in_ready);
        end
        bus.in_instr = enc_i(OP_ADDI, 5'd0, 5'd3, 16'h0001);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_r3_waw: in_ready got %b want 0", bus.in_ready);
        end
        bus.in_instr = 32'd0;
        tick();
        do_wb(5'd3, 32'h33);
    endtask

    task automatic test_raw();
        exp_t e;
        logic [31:0] ins;
        ins = enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0005);
        bus.in_instr = ins;
        bus.in_valid = 1'b1;
        #1;
        sb.push_back({ins, 32'd0, model_gpr[1]});
        tick();
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL raw_first: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_instr !== e.instr ||
                bus.out_reg_a !== e.a || bus.out_reg_b !== e.b) begin
                errors++;
                $display("FAIL raw_first: got v=%b i=%h a=%h b=%h want v=1 i=%h a=%h b=%h",
                         bus.out_valid, bus.out_instr, bus.out_reg_a, bus.out_reg_b, e.instr, e.a, e.b);
            end
        end
        ins = enc_r(5'd1, 5'd2, 5'd4, FN_ADD);
        bus.in_instr = ins;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall: in_ready got %b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_bubble: out_valid=%b in_ready=%b want 0 0", bus.out_valid, bus.in_ready);
        end
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd1;
        bus.wb_data = 32'h0000000F;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_release: in_ready got %b want 1", bus.in_ready);
        end
        sb.push_back({ins, 32'h0000000F, model_gpr[2]});
        model_gpr[1] = 32'h0000000F;
        tick();
        bus.wb_en    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL raw_issue: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_instr !== e.instr ||
                bus.out_reg_a !== e.a || bus.out_reg_b !== e.b) begin
                errors++;
                $display("FAIL raw_issue: got v=%b i=%h a=%h b=%h want v=1 i=%h a=%h b=%h",
                         bus.out_valid, bus.out_instr, bus.out_reg_a, bus.out_reg_b, e.instr, e.a, e.b);
            end
        end
        do_wb(5'd4, 32'h44);
    endtask

    task automatic test_hold_refresh();
        exp_t e;
        logic [31:0] ins;
        bus.out_ready = 1'b0;
        ins = enc_i(OP_SW, 5'd4, 5'd2, 16'h0010);
        bus.in_instr = ins;
        bus.in_valid = 1'b1;
        #1;
        sb.push_back({ins, model_gpr[4], model_gpr[2]});
        tick();
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        bus.wb_en    = 1'b1;
        bus.wb_addr  = 5'd4;
        bus.wb_data  = 32'h0000ABCD;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_busy: in_ready got %b want 0", bus.in_ready);
        end
        model_gpr[4] = 32'h0000ABCD;
        sb[0].a = 32'h0000ABCD;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_reg_a !== 32'h0000ABCD || bus.out_instr !== ins) begin
            errors++;
            $display("FAIL hold_refresh_a: v=%b a=%h i=%h want v=1 a=0000abcd i=%h",
                     bus.out_valid, bus.out_reg_a, bus.out_instr, ins);
        end
        bus.wb_addr = 5'd9;
        bus.wb_data = 32'h00000999;
        model_gpr[9] = 32'h00000999;
        tick();
        bus.wb_addr = 5'd2;
        bus.wb_data = 32'h00002222;
        model_gpr[2] = 32'h00002222;
        sb[0].b = 32'h00002222;
        tick();
        bus.wb_en     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL hold_out: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_instr !== e.instr ||
                bus.out_reg_a !== e.a || bus.out_reg_b !== e.b) begin
                errors++;
                $display("FAIL hold_out: got v=%b i=%h a=%h b=%h want v=1 i=%h a=%h b=%h",
                         bus.out_valid, bus.out_instr, bus.out_reg_a, bus.out_reg_b, e.instr, e.a, e.b);
            end
        end
        tick();
    endtask

    task automatic test_r0();
        exp_t e;
        logic [31:0] ins;
        do_wb(5'd0, 32'hFFFFFFFF);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       ins = enc_r(5'd0, 5'd2, 5'd6, FN_OR);
                1:       ins = enc_r(5'd0, 5'd0, 5'd0, FN_ADDU);
                default: ins = enc_r(5'd0, 5'd0, 5'd7, FN_AND);
            endcase
            bus.in_instr = ins;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL r0_ready[%0d]: got %b want 1", k, bus.in_ready);
            end
            sb.push_back({ins, 32'd0, (k == 0) ? model_gpr[2] : 32'd0});
            tick();
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL r0_out[%0d]: scoreboard empty", k);
            end else begin
                e = sb.pop_front();
                if (bus.out_valid !== 1'b1 || bus.out_instr !== e.instr ||
                    bus.out_reg_a !== e.a || bus.out_reg_b !== e.b) begin
                    errors++;
                    $display("FAIL r0_out[%0d]: got v=%b i=%h a=%h b=%h want v=1 i=%h a=%h b=%h", k,
                             bus.out_valid, bus.out_instr, bus.out_reg_a, bus.out_reg_b, e.instr, e.a, e.b);
                end
            end
        end
        bus.in_valid = 1'b0;
        do_wb(5'd6, 32'h66);
        do_wb(5'd7, 32'h77);
    endtask

    task automatic test_sw_beq();
        exp_t e;
        logic [31:0] ins;
        logic [31:0] sw_i;
        logic [31:0] beq_i;
        sw_i  = enc_i(OP_SW, 5'd5, 5'd5, 16'h0004);
        beq_i = enc_i(OP_BEQ, 5'd5, 5'd5, 16'h0008);
        ins = enc_i(OP_LW, 5'd0, 5'd5, 16'h0000);
        bus.in_instr = ins;
        bus.in_valid = 1'b1;
        #1;
        sb.push_back({ins, 32'd0, model_gpr[5]});
        tick();
        void'(sb.pop_front());
        bus.in_instr = sw_i;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sw_stall: in_ready got %b want 0", bus.in_ready);
        end
        bus.in_instr = beq_i;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL beq_stall: in_ready got %b want 0", bus.in_ready);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin
                    ins = sw_i;
                    bus.wb_en   = 1'b1;
                    bus.wb_addr = 5'd5;
                    bus.wb_data = 32'h55;
                    model_gpr[5] = 32'h55;
                end
                1:       ins = beq_i;
                default: ins = enc_i(OP_LW, 5'd0, 5'd5, 16'h0008);
            endcase
            bus.in_instr = ins;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sw_beq_issue[%0d]: in_ready got %b want 1", k, bus.in_ready);
            end
            sb.push_back({ins, (k == 2) ? 32'd0 : 32'h55, 32'h55});
            tick();
            bus.wb_en = 1'b0;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sw_beq_out[%0d]: scoreboard empty", k);
            end else begin
                e = sb.pop_front();
                if (bus.out_valid !== 1'b1 || bus.out_instr !== e.instr ||
                    bus.out_reg_a !== e.a || bus.out_reg_b !== e.b) begin
                    errors++;
                    $display("FAIL sw_beq_out[%0d]: got v=%b i=%h a=%h b=%h want v=1 i=%h a=%h b=%h", k,
                             bus.out_valid, bus.out_instr, bus.out_reg_a, bus.out_reg_b, e.instr, e.a, e.b);
                end
            end
        end
        bus.in_valid = 1'b0;
        do_wb(5'd5, 32'h5A);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] ins;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] ea;
        logic [31:0] eb;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            wa = (i % 4 == 1) ? rs : 5'($urandom_range(0, 31));
            wd = $urandom;
            ins = enc_i((i % 2 == 0) ? OP_SW : OP_BEQ, rs, rt, 16'(i));
            bus.in_instr = ins;
            bus.wb_en    = (i % 2 == 1);
            bus.wb_addr  = wa;
            bus.wb_data  = wd;
            ea = (bus.wb_en && wa != 5'd0 && wa == rs) ? wd : model_gpr[rs];
            eb = (bus.wb_en && wa != 5'd0 && wa == rt) ? wd : model_gpr[rt];
            if (bus.wb_en && wa != 5'd0) model_gpr[wa] = wd;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.in_ready);
            end
            sb.push_back({ins, ea, eb});
            tick();
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b_out[%0d]: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (bus.out_valid !== 1'b1 || bus.out_instr !== e.instr ||
                    bus.out_reg_a !== e.a || bus.out_reg_b !== e.b) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got v=%b i=%h a=%h b=%h want v=1 i=%h a=%h b=%h", i,
                             bus.out_valid, bus.out_instr, bus.out_reg_a, bus.out_reg_b, e.instr, e.a, e.b);
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        exp_t e;
        logic [31:0] ins;
        bus.out_ready = 1'b0;
        bus.in_instr  = enc_i(OP_LW, 5'd0, 5'd7, 16'h0000);
        bus.in_valid  = 1'b1;
        #1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold_setup: out_valid got %b want 1", bus.out_valid);
        end
        ins = enc_i(OP_SW, 5'd7, 5'd1, 16'h0000);
        bus.in_instr = ins;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold_reset: out_valid=%b out_instr=%h in_ready=%b want 0 0 1",
                     bus.out_valid, bus.out_instr, bus.in_ready);
        end
        sb.delete();
        for (int r = 0; r < 32; r++) model_gpr[r] = 32'd0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        sb.push_back({ins, model_gpr[7], model_gpr[1]});
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL post_reset_out: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_instr !== e.instr ||
                bus.out_reg_a !== e.a || bus.out_reg_b !== e.b) begin
                errors++;
                $display("FAIL post_reset_out: got v=%b i=%h a=%h b=%h want v=1 i=%h a=%h b=%h",
                         bus.out_valid, bus.out_instr, bus.out_reg_a, bus.out_reg_b, e.instr, e.a, e.b);
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b1;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = 5'd0;
        bus.wb_data   = 32'd0;
        for (int r = 0; r < 32; r++) model_gpr[r] = 32'd0;
        test_reset();
        test_basic();
        test_raw();
        test_hold_refresh();
        test_r0();
        test_sw_beq();
        test_back_to_back();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
